// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the memory arbiter.
// Optional feature macro: MEM_ARB_BYTE_WRITE_EN (byte-lane stores via read-modify-write).
package mem_arb_pkg;

    localparam int unsigned WORD_W    = 32;
    localparam logic [3:0]  STRB_FULL = 4'b1111;

    localparam logic PORT_I = 1'b0;
    localparam logic PORT_D = 1'b1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RMW    = 2'd2,
        RESP   = 2'd3
    } state_t;

    // Replace the byte lanes of old_w selected by strb with those of new_w.
    function automatic logic [WORD_W-1:0] merge_bytes(
        input logic [WORD_W-1:0] old_w,
        input logic [WORD_W-1:0] new_w,
        input logic [3:0]        strb
    );
        logic [WORD_W-1:0] merged;
        merged = old_w;
        for (int unsigned b = 0; b < 4; b++) begin
            if (strb[b]) begin
                merged[8*b +: 8] = new_w[8*b +: 8];
            end
        end
        return merged;
    endfunction

endpackage

// File: rtl/mem_arbiter_rr_arb2.sv
// Two-way round-robin picker between the fetch and data ports.
// Holds the last granted port; on a tie the other port wins.
module rr_arb2
    import mem_arb_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic i_req_i,
    input  logic d_req_i,
    input  logic update_i,
    output logic valid_o,
    output logic grant_o
);

    logic last_grant_q;
    logic last_grant_d;

    // Combinational pick: single requester wins, tie goes to the port not granted last.
    always_comb begin
        valid_o = i_req_i | d_req_i;
        grant_o = PORT_I;
        if (i_req_i && d_req_i) begin
            grant_o = (last_grant_q == PORT_I) ? PORT_D : PORT_I;
        end else if (d_req_i) begin
            grant_o = PORT_D;
        end
        last_grant_d = (update_i && valid_o) ? grant_o : last_grant_q;
    end

    // Remember the most recent grant; reset favours the fetch port on the first tie.
    always_ff @(posedge clk) begin
        if (reset) begin
            last_grant_q <= PORT_D;
        end else begin
            last_grant_q <= last_grant_d;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Arbiter sharing one single-port word memory between instruction fetch and load/store.
// Optional feature macro: MEM_ARB_BYTE_WRITE_EN. When defined, partial-strobe stores
// perform a read-modify-write through the RMW state; otherwise every store writes the
// full word and d_wstrb is ignored.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned MEM_WORDS = 1024,
    parameter int unsigned IDX_LSB   = 2,
    parameter int unsigned IDX_MSB   = 13
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_req,
    input  logic [WORD_W-1:0] i_addr,
    output logic              i_ack,
    output logic [WORD_W-1:0] i_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [WORD_W-1:0] d_addr,
    input  logic [WORD_W-1:0] d_wdata,
    input  logic [3:0]        d_wstrb,
    output logic              d_ack,
    output logic [WORD_W-1:0] d_rdata,
    output logic              d_err,
    output logic [WORD_W-1:0] mem_address,
    output logic [WORD_W-1:0] mem_data_in,
    output logic              mem_we,
    input  logic [WORD_W-1:0] mem_data_out
);

    state_t            state_q;
    logic              port_q;
    logic              we_q;
    logic              oor_q;
    logic [WORD_W-1:0] addr_q;
    logic [WORD_W-1:0] data_in_q;
    logic              mem_we_q;
    logic              i_ack_q;
    logic              d_ack_q;
    logic              d_err_q;
    logic [WORD_W-1:0] i_rdata_q;
    logic [WORD_W-1:0] d_rdata_q;
`ifdef MEM_ARB_BYTE_WRITE_EN
    logic [3:0]        strb_q;
`else
    logic              unused_wstrb;
    assign unused_wstrb = ^d_wstrb;
`endif

    logic              grant_valid;
    logic              grant;
    logic [WORD_W-1:0] sel_addr;
    logic              sel_we;
    logic              sel_oor;
    logic              sel_full_write;

    function automatic logic out_of_range(input logic [WORD_W-1:0] a);
        return 32'(a[IDX_MSB:IDX_LSB]) >= MEM_WORDS;
    endfunction

    rr_arb2 u_rr_arb2 (
        .clk      (clk),
        .reset    (reset),
        .i_req_i  (i_req),
        .d_req_i  (d_req),
        .update_i (state_q == IDLE),
        .valid_o  (grant_valid),
        .grant_o  (grant)
    );

    // Select the winning port's request fields for latching in IDLE.
    always_comb begin
        sel_addr = (grant == PORT_D) ? d_addr : i_addr;
        sel_we   = (grant == PORT_D) && d_we;
        sel_oor  = out_of_range(sel_addr);
`ifdef MEM_ARB_BYTE_WRITE_EN
        sel_full_write = (d_wstrb == STRB_FULL);
`else
        sel_full_write = 1'b1;
`endif
    end

    // Access sequencer: latch request, access memory, optional RMW, one-cycle ack.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            port_q    <= PORT_I;
            we_q      <= 1'b0;
            oor_q     <= 1'b0;
            addr_q    <= '0;
            data_in_q <= '0;
            mem_we_q  <= 1'b0;
            i_ack_q   <= 1'b0;
            d_ack_q   <= 1'b0;
            d_err_q   <= 1'b0;
            i_rdata_q <= '0;
            d_rdata_q <= '0;
`ifdef MEM_ARB_BYTE_WRITE_EN
            strb_q    <= '0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    mem_we_q <= 1'b0;
                    if (grant_valid) begin
                        port_q   <= grant;
                        we_q     <= sel_we;
                        oor_q    <= sel_oor;
                        addr_q   <= sel_addr;
                        // Write enable is registered here so it is already high during ACCESS.
                        mem_we_q <= sel_we && !sel_oor && sel_full_write;
                        if (sel_we) begin
                            data_in_q <= d_wdata;
                        end
`ifdef MEM_ARB_BYTE_WRITE_EN
                        strb_q <= d_wstrb;
`endif
                        state_q <= ACCESS;
                    end
                end
                ACCESS: begin
                    mem_we_q <= 1'b0;
`ifdef MEM_ARB_BYTE_WRITE_EN
                    if (we_q && !oor_q && (strb_q != 4'b0000) && (strb_q != STRB_FULL)) begin
                        data_in_q <= merge_bytes(mem_data_out, data_in_q, strb_q);
                        mem_we_q  <= 1'b1;
                        state_q   <= RMW;
                    end else begin
`else
                    begin
`endif
                        if (!we_q) begin
                            if (port_q == PORT_I) begin
                                i_rdata_q <= oor_q ? '0 : mem_data_out;
                            end else begin
                                d_rdata_q <= oor_q ? '0 : mem_data_out;
                            end
                        end
                        i_ack_q <= (port_q == PORT_I);
                        d_ack_q <= (port_q == PORT_D);
                        d_err_q <= (port_q == PORT_D) && oor_q;
                        state_q <= RESP;
                    end
                end
`ifdef MEM_ARB_BYTE_WRITE_EN
                RMW: begin
                    mem_we_q <= 1'b0;
                    i_ack_q  <= (port_q == PORT_I);
                    d_ack_q  <= (port_q == PORT_D);
                    d_err_q  <= 1'b0;
                    state_q  <= RESP;
                end
`endif
                RESP: begin
                    i_ack_q <= 1'b0;
                    d_ack_q <= 1'b0;
                    d_err_q <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    mem_we_q <= 1'b0;
                    state_q  <= IDLE;
                end
            endcase
        end
    end

    // Reset gates the write strobe so an aborted access never writes in the reset cycle.
    assign mem_we      = mem_we_q & ~reset;
    assign mem_address = addr_q;
    assign mem_data_in = data_in_q;
    assign i_ack       = i_ack_q;
    assign d_ack       = d_ack_q;
    assign d_err       = d_err_q;
    assign i_rdata     = i_rdata_q;
    assign d_rdata     = d_rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter with a behavioural word memory.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        i_req;
    logic [31:0] i_addr;
    logic        i_ack;
    logic [31:0] i_rdata;
    logic        d_req;
    logic        d_we;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [3:0]  d_wstrb;
    logic        d_ack;
    logic [31:0] d_rdata;
    logic        d_err;
    logic [31:0] mem_address;
    logic [31:0] mem_data_in;
    logic        mem_we;
    logic [31:0] mem_data_out;

    int checks = 0;
    int errors = 0;

    // Behavioural memory: 4096 entries so out-of-range indices still read real data.
    logic [31:0] mem [0:4095];
    logic        pl_en = 1'b0;
    logic [11:0] pl_idx = '0;
    logic [31:0] pl_data = '0;

    assign mem_data_out = mem[mem_address[13:2]];

    always @(posedge clk) begin
        if (pl_en) mem[pl_idx] <= pl_data;
        else if (mem_we) mem[mem_address[13:2]] <= mem_data_in;
    end

    always #5 clk = ~clk;

    mem_arbiter dut (
        .clk          (clk),
        .reset        (reset),
        .i_req        (i_req),
        .i_addr       (i_addr),
        .i_ack        (i_ack),
        .i_rdata      (i_rdata),
        .d_req        (d_req),
        .d_we         (d_we),
        .d_addr       (d_addr),
        .d_wdata      (d_wdata),
        .d_wstrb      (d_wstrb),
        .d_ack        (d_ack),
        .d_rdata      (d_rdata),
        .d_err        (d_err),
        .mem_address  (mem_address),
        .mem_data_in  (mem_data_in),
        .mem_we       (mem_we),
        .mem_data_out (mem_data_out)
    );

    // Observations from the last run() window.
    int unsigned iq[$];
    int unsigned dq[$];
    logic [31:0] ird[$];
    logic [31:0] drd[$];
    logic        derr[$];
    logic        order[$];
    int          we_cnt;

    task automatic preload(input int idx, input logic [31:0] data);
        @(posedge clk); #1;
        pl_en = 1'b1; pl_idx = 12'(idx); pl_data = data;
        @(posedge clk); #1;
        pl_en = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1; i_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
        @(posedge clk); @(posedge clk); #1;
        reset = 1'b0;
    endtask

    // Observe n cycles (cycle 0 = the cycle the request was raised); drop reqs on ack unless held.
    task automatic run(input int n, input bit hold_i, input bit hold_d);
        iq.delete(); dq.delete(); ird.delete(); drd.delete(); derr.delete(); order.delete();
        we_cnt = 0;
        for (int c = 0; c < n; c++) begin
            @(negedge clk);
            if (mem_we === 1'b1) we_cnt++;
            if (i_ack === 1'b1) begin
                iq.push_back(c); ird.push_back(i_rdata); order.push_back(1'b0);
                if (!hold_i) i_req = 1'b0;
            end
            if (d_ack === 1'b1) begin
                dq.push_back(c); drd.push_back(d_rdata); derr.push_back(d_err); order.push_back(1'b1);
                if (!hold_d) begin d_req = 1'b0; d_we = 1'b0; end
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; i_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
        i_addr = '0; d_addr = '0; d_wdata = '0; d_wstrb = '0;
        @(posedge clk); @(posedge clk);
        @(negedge clk);
        checks++;
        if ({i_ack, d_ack, d_err, mem_we} !== 4'b0000) begin
            errors++; $display("FAIL reset_flags: got %b want 0000", {i_ack, d_ack, d_err, mem_we});
        end
        checks++;
        if ({mem_address, mem_data_in, i_rdata, d_rdata} !== 128'd0) begin
            errors++; $display("FAIL reset_words: addr=%h din=%h ir=%h dr=%h want all 0",
                               mem_address, mem_data_in, i_rdata, d_rdata);
        end
        @(posedge clk); #1;
        reset = 1'b0;
    endtask

    task automatic test_fetch();
        preload(5, 32'h00500093);
        @(posedge clk); #1;
        i_req = 1'b1; i_addr = 32'h14;
        run(6, 0, 0);
        checks++;
        if (iq.size() != 1 || iq[0] != 2) begin
            errors++; $display("FAIL fetch_latency: acks=%0d first=%0d want 1 ack at cycle 2",
                               iq.size(), (iq.size() > 0) ? iq[0] : 0);
        end
        checks++;
        if (ird.size() < 1 || ird[0] !== 32'h00500093) begin
            errors++; $display("FAIL fetch_data: got %h want 00500093", (ird.size() > 0) ? ird[0] : 32'hx);
        end
        checks++;
        if (dq.size() != 0 || we_cnt != 0) begin
            errors++; $display("FAIL fetch_side: d_acks=%0d writes=%0d want 0 0", dq.size(), we_cnt);
        end
    endtask

    task automatic test_simultaneous();
        preload(16, 32'h12345678);
        do_reset();
        i_req = 1'b1; i_addr = 32'h14; d_req = 1'b1; d_we = 1'b0; d_addr = 32'h40;
        run(8, 0, 0);
        checks++;
        if (iq.size() != 1 || iq[0] != 2 || dq.size() != 1 || dq[0] != 5) begin
            errors++; $display("FAIL simul_order: i=%0d@%0d d=%0d@%0d want I@2 D@5",
                               iq.size(), (iq.size() > 0) ? iq[0] : 0, dq.size(), (dq.size() > 0) ? dq[0] : 0);
        end
        checks++;
        if (drd.size() < 1 || drd[0] !== 32'h12345678 || derr[0] !== 1'b0) begin
            errors++; $display("FAIL simul_dload: got %h err=%b want 12345678 err=0",
                               (drd.size() > 0) ? drd[0] : 32'hx, (derr.size() > 0) ? derr[0] : 1'bx);
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        i_req = 1'b1; i_addr = 32'h14; d_req = 1'b1; d_we = 1'b0; d_addr = 32'h40;
        run(15, 1, 1);
        i_req = 1'b0; d_req = 1'b0;
        checks++;
        if (order.size() != 5 || order[0] !== 1'b0 || order[1] !== 1'b1 ||
            order[2] !== 1'b0 || order[3] !== 1'b1 || order[4] !== 1'b0) begin
            errors++; $display("FAIL rr_alternate: %0d acks, want I D I D I", order.size());
        end
        checks++;
        if (iq.size() != 3 || iq[1] != 8 || dq.size() != 2 || dq[1] != 11) begin
            errors++; $display("FAIL rr_timing: i2=%0d d2=%0d want 8 11",
                               (iq.size() > 1) ? iq[1] : 0, (dq.size() > 1) ? dq[1] : 0);
        end
        run(4, 0, 0);
    endtask

    task automatic test_store_full();
        @(posedge clk); #1;
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h40; d_wdata = 32'hDEADBEEF; d_wstrb = 4'hF;
        run(6, 0, 0);
        checks++;
        if (we_cnt != 1 || dq.size() != 1 || dq[0] != 2) begin
            errors++; $display("FAIL store_full: writes=%0d ack=%0d want 1 write ack@2",
                               we_cnt, (dq.size() > 0) ? dq[0] : 0);
        end
        checks++;
        if (mem[16] !== 32'hDEADBEEF) begin
            errors++; $display("FAIL store_full_mem: got %h want DEADBEEF", mem[16]);
        end
        @(posedge clk); #1;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h40;
        run(5, 0, 0);
        checks++;
        if (drd.size() != 1 || drd[0] !== 32'hDEADBEEF) begin
            errors++; $display("FAIL load_back: got %h want DEADBEEF", (drd.size() > 0) ? drd[0] : 32'hx);
        end
    endtask

    task automatic test_partial_strobe();
        preload(8, 32'h11223344);
        @(posedge clk); #1;
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h20; d_wdata = 32'hAABBCCDD; d_wstrb = 4'b0101;
        run(7, 0, 0);
`ifdef MEM_ARB_BYTE_WRITE_EN
        checks++;
        if (dq.size() != 1 || dq[0] != 3 || we_cnt != 1) begin
            errors++; $display("FAIL partial_timing: ack=%0d writes=%0d want ack@3 1 write",
                               (dq.size() > 0) ? dq[0] : 0, we_cnt);
        end
        checks++;
        if (mem[8] !== 32'h11BB33DD) begin
            errors++; $display("FAIL partial_merge: got %h want 11BB33DD", mem[8]);
        end
`else
        checks++;
        if (dq.size() != 1 || dq[0] != 2 || we_cnt != 1) begin
            errors++; $display("FAIL partial_timing: ack=%0d writes=%0d want ack@2 1 write",
                               (dq.size() > 0) ? dq[0] : 0, we_cnt);
        end
        checks++;
        if (mem[8] !== 32'hAABBCCDD) begin
            errors++; $display("FAIL partial_merge: got %h want AABBCCDD", mem[8]);
        end
`endif
        checks++;
        if (d_rdata !== 32'hDEADBEEF) begin
            errors++; $display("FAIL store_keeps_rdata: got %h want DEADBEEF", d_rdata);
        end
        preload(9, 32'h55667788);
        @(posedge clk); #1;
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h24; d_wdata = 32'h99999999; d_wstrb = 4'b0000;
        run(6, 0, 0);
        checks++;
`ifdef MEM_ARB_BYTE_WRITE_EN
        if (we_cnt != 0 || mem[9] !== 32'h55667788 || dq.size() != 1) begin
            errors++; $display("FAIL zero_strobe: writes=%0d mem=%h want 0 writes 55667788", we_cnt, mem[9]);
        end
`else
        if (we_cnt != 1 || mem[9] !== 32'h99999999 || dq.size() != 1) begin
            errors++; $display("FAIL zero_strobe: writes=%0d mem=%h want 1 write 99999999", we_cnt, mem[9]);
        end
`endif
    endtask

    task automatic test_out_of_range();
        preload(1024, 32'hCAFEF00D);
        @(posedge clk); #1;
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h1000; d_wdata = 32'h0BADBAD0; d_wstrb = 4'hF;
        run(6, 0, 0);
        checks++;
        if (we_cnt != 0 || mem[1024] !== 32'hCAFEF00D) begin
            errors++; $display("FAIL oor_store_write: writes=%0d mem=%h want 0 CAFEF00D", we_cnt, mem[1024]);
        end
        checks++;
        if (dq.size() != 1 || derr[0] !== 1'b1) begin
            errors++; $display("FAIL oor_store_err: acks=%0d err=%b want 1 1",
                               dq.size(), (derr.size() > 0) ? derr[0] : 1'bx);
        end
        @(posedge clk); #1;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h1000;
        run(5, 0, 0);
        checks++;
        if (drd.size() != 1 || drd[0] !== 32'h0 || derr[0] !== 1'b1) begin
            errors++; $display("FAIL oor_load: got %h err=%b want 0 err=1",
                               (drd.size() > 0) ? drd[0] : 32'hx, (derr.size() > 0) ? derr[0] : 1'bx);
        end
        @(posedge clk); #1;
        i_req = 1'b1; i_addr = 32'h1000;
        run(5, 0, 0);
        checks++;
        if (ird.size() != 1 || ird[0] !== 32'h0 || d_err !== 1'b0) begin
            errors++; $display("FAIL oor_fetch: got %h want 0", (ird.size() > 0) ? ird[0] : 32'hx);
        end
    endtask

    task automatic test_reset_mid_store();
        preload(17, 32'h01010101);
        @(posedge clk); #1;
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h44; d_wdata = 32'hFFFF0000; d_wstrb = 4'hF;
        @(posedge clk); #1;
        reset = 1'b1;
        @(negedge clk);
        checks++;
        if (mem_we !== 1'b0) begin
            errors++; $display("FAIL reset_cycle_we: got %b want 0", mem_we);
        end
        @(posedge clk); #1;
        reset = 1'b0; d_req = 1'b0; d_we = 1'b0;
        run(4, 0, 0);
        checks++;
        if (iq.size() != 0 || dq.size() != 0 || mem[17] !== 32'h01010101 || mem_address !== 32'h0) begin
            errors++; $display("FAIL reset_abort: acks=%0d/%0d mem=%h addr=%h want none 01010101 0",
                               iq.size(), dq.size(), mem[17], mem_address);
        end
        @(posedge clk); #1;
        i_req = 1'b1; i_addr = 32'h14;
        run(5, 0, 0);
        checks++;
        if (iq.size() != 1 || iq[0] != 2 || ird[0] !== 32'h00500093) begin
            errors++; $display("FAIL reset_idle_fetch: ack=%0d want ack@2 data 00500093",
                               (iq.size() > 0) ? iq[0] : 0);
        end
    endtask

    initial begin
        test_reset();
        test_fetch();
        test_simultaneous();
        test_back_to_back();
        test_store_full();
        test_partial_strobe();
        test_out_of_range();
        test_reset_mid_store();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
